uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter: the outbound counterpart of the core's io_rx receive path.
//   - Accepts bytes from the core or a debug master over a valid/ready handshake.
//   - Buffers them in a small FIFO and drives them onto io_tx as 8N1 frames (8E1 with parity).
//   - Sits at the top level next to cpu; io_tx goes to the board pin.
// PARAMETERS
//   CLK_FREQ_HZ  100_000_000  clk frequency in Hz
//   BAUD_RATE    115_200      line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer, truncated, must be >= 2)
//   FIFO_DEPTH   4            byte FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1                    system clock, all logic on rising edge
//   reset       in   1                    synchronous, active-high
//   tx_data     in   8                    byte to send, LSB transmitted first
//   tx_valid    in   1                    tx_data valid this cycle
//   tx_ready    out  1                    FIFO can accept a byte this cycle
//   io_tx       out  1                    serial line, idle high
//   tx_busy     out  1                    FIFO non-empty or a frame is in flight
//   fifo_count  out  $clog2(FIFO_DEPTH)+1 bytes currently queued (excludes the byte being shifted)
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - Reset values: io_tx=1, tx_ready=1, tx_busy=0, fifo_count=0. FSM goes to IDLE; FIFO pointers clear.
//   - Reset mid-frame: the frame is abandoned and io_tx=1 from the reset edge. No partial byte resumes afterwards.
//   - Handshake: a byte is pushed on any edge where tx_valid && tx_ready.
//     - tx_ready = (fifo_count != FIFO_DEPTH), derived from the registered count only.
//     - When full, a push is refused even if a pop occurs in the same cycle.
//     - tx_data is sampled only on the push edge.
//   - Simultaneous push and pop (count not full): count is unchanged and the data order is preserved.
//   - Pointers wrap modulo FIFO_DEPTH. Count saturates neither way; overflow and underflow are impossible by construction.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//     - IDLE: io_tx=1. If fifo_count != 0: pop the head into the shift register, clear the baud counter, enter START.
//     - START: io_tx=0 for CLKS_PER_BIT cycles.
//     - DATA: 8 bits, each held CLKS_PER_BIT cycles, LSB first. A 3-bit index counts 0..7.
//     - PARITY: present only when the feature is enabled (see CONFIGURATION).
//     - STOP: io_tx=1 for CLKS_PER_BIT cycles. On its final cycle: if the FIFO is non-empty, pop and go straight
//       to START (no idle gap, back-to-back frames); otherwise go to IDLE.
//   - Latency: a byte pushed at edge E0 into an empty FIFO while idle makes io_tx fall at edge E1 (one cycle later).
//   - io_tx is driven from a flop (glitch-free). Each bit period is exactly CLKS_PER_BIT cycles.
//     - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
//   - Frame length: 10*CLKS_PER_BIT cycles (11 with parity).
//   - tx_busy = (state != IDLE) || (fifo_count != 0). It drops on the edge the last STOP bit completes.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - PARITY state is inserted between DATA and STOP.
//     - io_tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
//     - Frame is 8E1, 11 bit periods.
//   UART_TX_PARITY_EN undefined: no PARITY state or logic; frame is 8N1, 10 bit periods.
// TESTING  (CLK_FREQ_HZ=16, BAUD_RATE=1 -> CLKS_PER_BIT=16, FIFO_DEPTH=4)
//   1. Reset held 3 cycles, then released -> io_tx=1, tx_ready=1, tx_busy=0, fifo_count=0 every cycle.
//   2. Push 0xA5 at edge E0 -> io_tx low from E1 for 16 cycles.
//      - Then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high for 16 cycles.
//      - tx_busy falls at E1+160.
//   3. Push 0x00,0xFF,0x55,0x0F,0x33 on consecutive cycles:
//      - tx_ready=0 after 5 accepts (1 popped + 4 queued).
//      - Sixth push is refused until the next pop.
//      - 5 frames emitted in order with no idle gap; io_tx low at frame starts 160 cycles apart.
//   4. Push while full with a pop on the same edge -> byte rejected (tx_ready was 0); fifo_count 4->3.
//   5. Assert reset at cycle 70 of a frame -> io_tx=1 and fifo_count=0 from that edge. No further frames after release.
//   6. With UART_TX_PARITY_EN, send 0x07 -> parity bit=1, frame 176 cycles. Send 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : Byte FIFO plus 8N1 serial transmitter; define UART_TX_PARITY_EN
//            for 8E1 frames with an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
  localparam int c_PTR_W        = $clog2(FIFO_DEPTH);
  localparam int c_COUNT_W      = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]   c_BAUD_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_COUNT_W-1:0] c_FULL      = c_COUNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_COUNT_W-1:0] r_count;
  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic [c_CNT_W-1:0]   r_baud_cnt;
  logic                 r_tx;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_tx_next;
  logic w_shift_adv;
  logic w_baud_last;
  logic w_fifo_nonempty;

  assign w_ready         = (r_count != c_FULL);
  assign w_push          = tx_valid && w_ready;
  assign w_baud_last     = (r_baud_cnt == c_BAUD_LAST);
  assign w_fifo_nonempty = (r_count != '0);

  assign tx_ready   = w_ready;
  assign io_tx      = r_tx;
  assign tx_busy    = (r_state != ST_IDLE) || w_fifo_nonempty;
  assign fifo_count = r_count;

  // Next-state logic also computes the next line level so io_tx is a flop
  // that changes on the same edge as the state.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = r_tx;
    w_shift_adv  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          w_state_next = ST_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_shift_adv = 1'b1;
            w_tx_next   = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_last) begin
          w_state_next = ST_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_last) begin
          if (w_fifo_nonempty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
        r_shift    <= r_mem[r_rd_ptr];
        r_bit_idx  <= '0;
        r_baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity   <= ^r_mem[r_rd_ptr];
`endif
      end else if (r_state != ST_IDLE) begin
        r_baud_cnt <= w_baud_last ? '0 : r_baud_cnt + c_CNT_W'(1);
      end

      if (w_shift_adv) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      // Push and pop together leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_COUNT_W'(1);
        2'b01:   r_count <= r_count - c_COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx against a queue/frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       io_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx #(
    .CLK_FREQ_HZ (16),
    .BAUD_RATE   (1),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .io_tx      (io_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queued bytes, byte on the wire, and cycle position inside its frame.
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;
  bit         m_acc = 1'b0;
  bit         m_pop_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit full;
    bit endf;
    logic exp_tx;
    tx_valid = v;
    tx_data  = d;
    reset    = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      pos        = -1;
      m_acc      = 1'b0;
      m_pop_full = 1'b0;
    end else begin
      full       = (mq.size() == DEPTH);
      m_acc      = v && !full;
      endf       = (pos == FRAME - 1);
      m_pop_full = 1'b0;
      if ((pos < 0 || endf) && mq.size() != 0) begin
        m_pop_full = full;
        cur        = mq.pop_front();
        pos        = 0;
      end else if (endf) begin
        pos = -1;
      end else if (pos >= 0) begin
        pos++;
      end
      if (m_acc) mq.push_back(d);
    end
    #1;
    exp_tx = (pos < 0) ? 1'b1 : frame_bit(cur, pos / CPB);
    check("io_tx", io_tx, exp_tx);
    check("tx_ready", tx_ready, mq.size() != DEPTH);
    check("tx_busy", tx_busy, (pos >= 0) || (mq.size() != 0));
    check("fifo_count", fifo_count, mq.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((pos >= 0 || mq.size() != 0) && k < max) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("drain_bound", k < max, 1);
  endtask

  // Sends one byte into an idle transmitter and measures frame length from io_tx falling.
  task automatic send_one(input logic [7:0] b, input string tag);
    int k = 0;
    step(1'b1, b, 1'b0);
    check({tag, "_lat0"}, io_tx, 1);
    step(1'b0, 8'h00, 1'b0);
    check({tag, "_start"}, io_tx, 0);
    while (tx_busy === 1'b1 && k < 400) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check({tag, "_frame_len"}, k, FRAME);
  endtask

  logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h33, 8'hC3};

  initial begin
    int k;
    int rate;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    reset    = 1'b1;

    // Reset held three cycles, then quiet line.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("rst_io_tx", io_tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_count", fifo_count, 0);
    end

    send_one(8'hA5, "a5");
    idle(5);

    // Burst of six: five fit (one popped, four queued), sixth waits for a pop.
    for (int i = 0; i < 6; i++) begin
      k = 0;
      do begin
        step(1'b1, burst[i], 1'b0);
        k++;
        if (m_pop_full) begin
          check("full_pop_count", fifo_count, 3);
          check("full_pop_ready", tx_ready, 1);
        end
      end while (!m_acc && k < 400);
      check("burst_accept_bound", k < 400, 1);
      if (i == 4) begin
        check("burst_full_count", fifo_count, 4);
        check("burst_full_ready", tx_ready, 0);
      end
    end
    drain(2000);
    idle(3);

    // Randomised traffic at several offered loads.
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 3 == 0) ? 5 : (blk % 3 == 1) ? 30 : 90;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < rate, 8'($urandom), 1'b0);
      end
    end
    drain(2000);

    // Reset in the middle of a frame with bytes still queued.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    k = 0;
    while (pos != 70 && k < 200) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("mid_reset_reach", k < 200, 1);
    step(1'b0, 8'h00, 1'b1);
    check("mid_reset_io_tx", io_tx, 1);
    check("mid_reset_count", fifo_count, 0);
    idle(2 * FRAME);
    check("post_reset_busy", tx_busy, 0);
    check("post_reset_io_tx", io_tx, 1);

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    idle(9 * CPB + 8);
    check("par07_bit", io_tx, 1);
    drain(400);
    step(1'b1, 8'h03, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    idle(9 * CPB + 8);
    check("par03_bit", io_tx, 0);
    drain(400);
    send_one(8'h07, "p07");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
